// File: rtl/sync_fifo_ram_pkg.sv
// Shared width helpers for the single-clock RAM-based FIFO and its RAM.
package sync_fifo_ram_pkg;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Occupancy needs one extra bit to represent a completely full FIFO.
  function automatic int unsigned count_width(input int unsigned depth);
    return addr_width(depth) + 1;
  endfunction

  localparam int unsigned DEF_DEPTH   = 16;
  localparam int unsigned DEF_COUNT_W = count_width(DEF_DEPTH);

endpackage

// File: rtl/sync_fifo_ram_sdp_ram.sv
// Single-clock simple dual-port RAM; registered read returns old data on collision.
module sdp_ram
  import sync_fifo_ram_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [addr_width(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          re,
  input  logic [addr_width(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]              rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Both updates are non-blocking, so a same-address read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) rdata <= r_mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO over an sdp_ram: pointers, occupancy, threshold flags, error pulses.
module sync_fifo_ram
  import sync_fifo_ram_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rdata,
  output logic                           rd_valid,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic [count_width(DEPTH)-1:0]  count,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int unsigned AW = addr_width(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_rd_valid, r_overflow, r_underflow;
  logic             r_rd_loaded;
  logic             w_full, w_empty, w_wr_acc, w_rd_acc, w_ram_we, w_ram_re;
  logic [WIDTH-1:0] w_ram_rdata;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_rd_acc = rd_en & ~w_empty;
  assign w_wr_acc = wr_en & (~w_full | w_rd_acc);
  assign w_ram_we = w_wr_acc & ~rst;
  assign w_ram_re = w_rd_acc & ~rst;

  sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (r_wr_ptr[AW-1:0]),
    .wdata (wdata),
    .re    (w_ram_re),
    .raddr (r_rd_ptr[AW-1:0]),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rd_loaded <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + 1'b1;
      else if (!w_wr_acc && w_rd_acc) r_count <= r_count - 1'b1;
      r_rd_valid  <= w_rd_acc;
      r_overflow  <= wr_en & ~w_wr_acc;
      r_underflow <= rd_en & ~w_rd_acc;
      if (w_rd_acc) r_rd_loaded <= 1'b1;
    end
  end

  // The RAM has no reset, so rdata reads as zero until the first pop after reset.
  assign rdata        = r_rd_loaded ? w_ram_rdata : '0;
  assign rd_valid     = r_rd_valid;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_count == CW'(r_wr_ptr - r_rd_ptr));
      assert (!(w_full && w_empty));
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Self-checking bench: queue-based reference model, directed plan plus random traffic.
module tb_sync_fifo_ram;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rdata;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  sync_fifo_ram #(
    .WIDTH    (W),
    .DEPTH    (D),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wdata        (wdata),
    .rd_en        (rd_en),
    .rdata        (rdata),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is just a queue plus the last popped word.
  logic [W-1:0] q[$];
  logic [W-1:0] m_rdata = '0;
  bit m_rdv = 0, m_ovf = 0, m_udf = 0, chk_en = 0;

  always @(posedge clk) begin
    bit racc, wacc;
    if (rst) begin
      q.delete();
      m_rdata = '0;
      m_rdv = 0; m_ovf = 0; m_udf = 0;
      chk_en = 1;
    end else begin
      racc = rd_en && (q.size() != 0);
      wacc = wr_en && ((q.size() != D) || racc);
      if (racc) m_rdata = q.pop_front();
      if (wacc) q.push_back(wdata);
      m_rdv = racc;
      m_ovf = wr_en && !wacc;
      m_udf = rd_en && !racc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_full", 32'(full), 32'(q.size() == D));
      chk("m_empty", 32'(empty), 32'(q.size() == 0));
      chk("m_afull", 32'(almost_full), 32'(q.size() >= AF));
      chk("m_aempty", 32'(almost_empty), 32'(q.size() <= AE));
      chk("m_rdata", 32'(rdata), 32'(m_rdata));
      chk("m_rdvalid", 32'(rd_valid), 32'(m_rdv));
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
      chk("m_udf", 32'(underflow), 32'(m_udf));
    end
  end

  // Drive one cycle's inputs just after a falling edge, return at the next falling edge.
  task automatic cyc(input bit we, input logic [W-1:0] wd, input bit re, input bit r = 0);
    wr_en = we; wdata = wd; rd_en = re; rst = r;
    @(negedge clk);
    wr_en = 0; rd_en = 0; rst = 0;
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 8'h00, 0, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_rdvalid", 32'(rd_valid), 0);

    for (int i = 0; i < 16; i++) begin
      cyc(1, W'(i), 0);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_aempty", 32'(almost_empty), 32'(i + 1 <= 2));
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 14));
      chk("fill_ovf", 32'(overflow), 0);
    end
    chk("fill_full", 32'(full), 1);

    cyc(1, 8'hAA, 0);
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    cyc(0, 8'h00, 0);
    chk("ovf_clear", 32'(overflow), 0);

    for (int i = 0; i < 16; i++) begin
      cyc(0, 8'h00, 1);
      chk("drain_rdata", 32'(rdata), 32'(i));
      chk("drain_rdvalid", 32'(rd_valid), 1);
    end
    chk("drain_empty", 32'(empty), 1);
    cyc(0, 8'h00, 1);
    chk("udf_pulse", 32'(underflow), 1);
    chk("udf_rdvalid", 32'(rd_valid), 0);
    chk("udf_hold", 32'(rdata), 32'h0F);

    for (int i = 0; i < 16; i++) cyc(1, W'(i), 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, W'(8'h10 + i), 1);
      chk("wrap_rdata", 32'(rdata), (i < 16) ? 32'(i) : 32'(8'h10 + i - 16));
      chk("wrap_count", 32'(count), 16);
      chk("wrap_ovf", 32'(overflow), 0);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, 8'h00, 1);
      chk("wrap_tail", 32'(rdata), 32'(8'h14 + i));
    end

    cyc(1, 8'h55, 1);
    chk("nobypass_udf", 32'(underflow), 1);
    chk("nobypass_count", 32'(count), 1);
    chk("nobypass_rdvalid", 32'(rd_valid), 0);
    cyc(0, 8'h00, 1);
    chk("nobypass_rdata", 32'(rdata), 32'h55);
    chk("nobypass_rdv2", 32'(rd_valid), 1);

    for (int i = 0; i < 5; i++) cyc(1, W'(8'h30 + i), 0);
    cyc(1, 8'hEE, 1, 1);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_rdata", 32'(rdata), 0);
    chk("midrst_rdvalid", 32'(rd_valid), 0);
    cyc(1, 8'h77, 0);
    cyc(0, 8'h00, 1);
    chk("postrst_rdata", 32'(rdata), 32'h77);

    for (int i = 0; i < 3000; i++) begin
      int unsigned mode;
      mode = (i / 300) % 3;
      cyc(($urandom_range(0, 99) < (mode == 0 ? 70 : (mode == 1 ? 30 : 50))),
          W'($urandom), ($urandom_range(0, 99) < (mode == 1 ? 70 : (mode == 0 ? 30 : 50))),
          ($urandom_range(0, 399) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
